// File: rtl/cpu_pkg.sv
// Shared definitions for the one-cycle CPU: opcodes, ALU B-source codes and
// the run/halt/fault state encoding used by cpu_ctrl and cpu_data.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_LDR  = 4'h4;
  localparam logic [3:0] OP_STR  = 4'h5;
  localparam logic [3:0] OP_ALUR = 4'h6;
  localparam logic [3:0] OP_ALUM = 4'h7;
  localparam logic [3:0] OP_ALUI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JNZ  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_HLT  = 4'hE;
  localparam logic [3:0] OP_ILL  = 4'hF;

  localparam logic [1:0] B_IMM = 2'b00;
  localparam logic [1:0] B_REG = 2'b01;
  localparam logic [1:0] B_MEM = 2'b10;

  localparam logic [3:0] ALU_PASS_B = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Fetch/decode bundle between cpu_ctrl (master) and the instruction memory /
// cpu_data side (slave).
interface cpu_ctrl_if #(
  parameter int WIDTH          = 8,
  parameter int IWIDTH         = 4,
  parameter int INSTR_WIDTH    = 16,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2
);
  logic [INSTR_WIDTH-1:0]    instr;
  logic                      flag_z_in;
  logic [WIDTH-1:0]          pc;
  logic [REG_F_SEL_SIZE-1:0] reg_f_sel;
  logic                      en_reg_f;
  logic [WIDTH-1:0]          d_mem_addr;
  logic                      d_mem_addr_mode;
  logic                      en_d_mem;
  logic [IN_B_SEL_SIZE-1:0]  in_b_sel;
  logic [WIDTH-1:0]          imm;
  logic [IWIDTH-1:0]         alu_out;
  logic                      en_acc;
  logic                      halted;
  logic                      fault;

  modport master (
    input  instr, flag_z_in,
    output pc, reg_f_sel, en_reg_f, d_mem_addr, d_mem_addr_mode, en_d_mem,
           in_b_sel, imm, alu_out, en_acc, halted, fault
  );

  modport slave (
    output instr, flag_z_in,
    input  pc, reg_f_sel, en_reg_f, d_mem_addr, d_mem_addr_mode, en_d_mem,
           in_b_sel, imm, alu_out, en_acc, halted, fault
  );
endinterface

// File: rtl/cpu_call_stack.sv
// Hardware return stack for CALL/RET. Requests arrive already qualified
// against full/empty, so no overflow protection is repeated here.
module cpu_call_stack #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             pc_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(STACK_DEPTH) + 1;

  logic [PW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_mem [STACK_DEPTH];
  logic [PW-2:0]    w_top_idx;

  assign w_top_idx = r_ptr[PW-2:0] - (PW-1)'(1);
  assign dout      = r_mem[w_top_idx];
  assign full      = (r_ptr == PW'(STACK_DEPTH));
  assign empty     = (r_ptr == '0);

  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      r_ptr <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PW'(1);
    end else if (pop) begin
      r_ptr <= r_ptr - PW'(1);
    end
  end

  // Entries need no reset: only slots below the pointer are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_ptr[PW-2:0]] <= din;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Fetch and decode stage: PC, combinational instruction decode, branch/call
// resolution and the run/halt/fault state machine.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int IWIDTH         = 4,
  parameter int INSTR_WIDTH    = 16,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int STACK_DEPTH    = 4
) (
  input  logic      clk,
  input  logic      pc_rst,
  cpu_ctrl_if.master bus
);
  state_t                    r_state, w_state_nxt;
  logic [WIDTH-1:0]          r_pc, w_pc_nxt, w_pc_inc, w_ret_addr;
  logic [INSTR_WIDTH-1:0]    w_instr;
  logic [3:0]                w_op, w_sub;
  logic [7:0]                w_opd;
  logic                      w_run, w_push, w_pop, w_full, w_empty;
  logic [REG_F_SEL_SIZE-1:0] w_reg_f_sel;
  logic [WIDTH-1:0]          w_d_mem_addr, w_imm;
  logic [IN_B_SEL_SIZE-1:0]  w_in_b_sel;
  logic [IWIDTH-1:0]         w_alu_out;
  logic                      w_en_reg_f, w_en_d_mem, w_en_acc, w_d_mem_addr_mode;

  assign w_instr  = bus.instr;
  assign w_op     = w_instr[15:12];
  assign w_sub    = w_instr[11:8];
  assign w_opd    = w_instr[7:0];
  assign w_pc_inc = r_pc + WIDTH'(1);
  // Reset is folded in so enables drop the moment pc_rst rises.
  assign w_run    = (r_state == ST_RUN) && !pc_rst;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_reg_f_sel       = '0;
    w_en_reg_f        = 1'b0;
    w_d_mem_addr      = '0;
    w_d_mem_addr_mode = 1'b0;
    w_en_d_mem        = 1'b0;
    w_in_b_sel        = IN_B_SEL_SIZE'(B_IMM);
    w_imm             = '0;
    w_alu_out         = '0;
    w_en_acc          = 1'b0;
    if (w_run) begin
      w_pc_nxt = w_pc_inc;
      case (w_op)
        OP_NOP: ;
        OP_LDI: begin
          w_imm     = WIDTH'(w_opd);
          w_alu_out = IWIDTH'(ALU_PASS_B);
          w_en_acc  = 1'b1;
        end
        OP_LD: begin
          w_d_mem_addr      = WIDTH'(w_opd);
          w_d_mem_addr_mode = w_sub[0];
          w_in_b_sel        = IN_B_SEL_SIZE'(B_MEM);
          w_alu_out         = IWIDTH'(ALU_PASS_B);
          w_en_acc          = 1'b1;
        end
        OP_ST: begin
          w_d_mem_addr      = WIDTH'(w_opd);
          w_d_mem_addr_mode = w_sub[0];
          w_en_d_mem        = 1'b1;
        end
        OP_LDR: begin
          w_reg_f_sel = REG_F_SEL_SIZE'(w_sub);
          w_in_b_sel  = IN_B_SEL_SIZE'(B_REG);
          w_alu_out   = IWIDTH'(ALU_PASS_B);
          w_en_acc    = 1'b1;
        end
        OP_STR: begin
          w_reg_f_sel = REG_F_SEL_SIZE'(w_sub);
          w_en_reg_f  = 1'b1;
        end
        OP_ALUR: begin
          w_alu_out   = IWIDTH'(w_sub);
          w_reg_f_sel = REG_F_SEL_SIZE'(w_opd[3:0]);
          w_in_b_sel  = IN_B_SEL_SIZE'(B_REG);
          w_en_acc    = 1'b1;
        end
        OP_ALUM: begin
          w_alu_out    = IWIDTH'(w_sub);
          w_d_mem_addr = WIDTH'(w_opd);
          w_in_b_sel   = IN_B_SEL_SIZE'(B_MEM);
          w_en_acc     = 1'b1;
        end
        OP_ALUI: begin
          w_alu_out = IWIDTH'(w_sub);
          w_imm     = WIDTH'(w_opd);
          w_en_acc  = 1'b1;
        end
        OP_JMP: w_pc_nxt = WIDTH'(w_opd);
        OP_JZ:  if (bus.flag_z_in)  w_pc_nxt = WIDTH'(w_opd);
        OP_JNZ: if (!bus.flag_z_in) w_pc_nxt = WIDTH'(w_opd);
        OP_CALL: begin
          if (w_full) begin
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_FAULT;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = WIDTH'(w_opd);
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_FAULT;
          end else begin
            w_pop    = 1'b1;
            w_pc_nxt = w_ret_addr;
          end
        end
        OP_HLT: begin
          w_pc_nxt    = r_pc;
          w_state_nxt = ST_HALT;
        end
        default: begin
          w_pc_nxt    = r_pc;
          w_state_nxt = ST_FAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      r_pc    <= '0;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  cpu_call_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk    (clk),
    .pc_rst (pc_rst),
    .push   (w_push),
    .pop    (w_pop),
    .din    (w_pc_inc),
    .dout   (w_ret_addr),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign bus.pc              = r_pc;
  assign bus.reg_f_sel       = w_reg_f_sel;
  assign bus.en_reg_f        = w_en_reg_f;
  assign bus.d_mem_addr      = w_d_mem_addr;
  assign bus.d_mem_addr_mode = w_d_mem_addr_mode;
  assign bus.en_d_mem        = w_en_d_mem;
  assign bus.in_b_sel        = w_in_b_sel;
  assign bus.imm             = w_imm;
  assign bus.alu_out         = w_alu_out;
  assign bus.en_acc          = w_en_acc;
  assign bus.halted          = (r_state == ST_HALT);
  assign bus.fault           = (r_state == ST_FAULT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: decode vector table, directed
// branch/call/halt/wrap sequences, and random programs against a reference model.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        pc_rst = 1'b1;
  logic        use_mem = 1'b0;
  logic [15:0] instr_drv = 16'h0000;
  logic        flag = 1'b0;
  logic [15:0] imem [256];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  cpu_ctrl_if bus ();
  assign bus.instr     = use_mem ? imem[bus.pc] : instr_drv;
  assign bus.flag_z_in = flag;

  cpu_ctrl dut (
    .clk    (clk),
    .pc_rst (pc_rst),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] imm;
    logic [1:0] bsel;
    logic [3:0] alu;
    logic       acc;
    logic       regf;
    logic       dmem;
    logic [3:0] rsel;
    logic [7:0] addr;
    logic       mode;
  } ctl_t;

  typedef struct {
    logic [15:0] instr;
    logic        flag;
    ctl_t        c;
    logic [7:0]  npc;
    logic        hlt;
    logic        flt;
  } vec_t;

  vec_t vt [$];
  ctl_t z;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ctl(string t, ctl_t e);
    chk({t, ".imm"},       32'(bus.imm),             32'(e.imm));
    chk({t, ".in_b_sel"},  32'(bus.in_b_sel),        32'(e.bsel));
    chk({t, ".alu_out"},   32'(bus.alu_out),         32'(e.alu));
    chk({t, ".en_acc"},    32'(bus.en_acc),          32'(e.acc));
    chk({t, ".en_reg_f"},  32'(bus.en_reg_f),        32'(e.regf));
    chk({t, ".en_d_mem"},  32'(bus.en_d_mem),        32'(e.dmem));
    chk({t, ".reg_f_sel"}, 32'(bus.reg_f_sel),       32'(e.rsel));
    chk({t, ".d_mem_addr"},32'(bus.d_mem_addr),      32'(e.addr));
    chk({t, ".addr_mode"}, 32'(bus.d_mem_addr_mode), 32'(e.mode));
  endtask

  task automatic chk_no_en(string t);
    chk({t, ".en_acc"},   32'(bus.en_acc),   32'd0);
    chk({t, ".en_reg_f"}, 32'(bus.en_reg_f), 32'd0);
    chk({t, ".en_d_mem"}, 32'(bus.en_d_mem), 32'd0);
  endtask

  function automatic ctl_t mkc(logic [7:0] imm, logic [1:0] bsel, logic [3:0] alu,
                               logic acc, logic regf, logic dmem, logic [3:0] rsel,
                               logic [7:0] addr, logic mode);
    ctl_t c;
    c.imm = imm; c.bsel = bsel; c.alu = alu; c.acc = acc; c.regf = regf;
    c.dmem = dmem; c.rsel = rsel; c.addr = addr; c.mode = mode;
    return c;
  endfunction

  task automatic addv(logic [15:0] ins, logic f, ctl_t c, logic [7:0] npc,
                      logic hlt, logic flt);
    vec_t v;
    v.instr = ins; v.flag = f; v.c = c; v.npc = npc; v.hlt = hlt; v.flt = flt;
    vt.push_back(v);
  endtask

  // Control bundle derived straight from the opcode table.
  function automatic ctl_t ref_decode(logic [15:0] ins, logic run);
    ctl_t       c = '{default: '0};
    logic [3:0] s = ins[11:8];
    logic [7:0] d = ins[7:0];
    if (run) begin
      case (ins[15:12])
        4'h1: begin c.imm = d; c.alu = 4'hF; c.acc = 1'b1; end
        4'h2: begin c.addr = d; c.mode = s[0]; c.bsel = 2'b10; c.alu = 4'hF; c.acc = 1'b1; end
        4'h3: begin c.addr = d; c.mode = s[0]; c.dmem = 1'b1; end
        4'h4: begin c.rsel = s; c.bsel = 2'b01; c.alu = 4'hF; c.acc = 1'b1; end
        4'h5: begin c.rsel = s; c.regf = 1'b1; end
        4'h6: begin c.alu = s; c.rsel = d[3:0]; c.bsel = 2'b01; c.acc = 1'b1; end
        4'h7: begin c.alu = s; c.addr = d; c.bsel = 2'b10; c.acc = 1'b1; end
        4'h8: begin c.alu = s; c.imm = d; c.acc = 1'b1; end
        default: ;
      endcase
    end
    return c;
  endfunction

  function automatic logic [15:0] rnd_instr();
    logic [3:0] op = 4'($urandom_range(0, 15));
    if (op >= 4'hD && $urandom_range(0, 2) != 0) op = 4'($urandom_range(0, 12));
    return {op, 12'($urandom)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    pc_rst = 1'b1;
    @(negedge clk);
    pc_rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    z = '{default: '0};

    // ---------------- decode vector table (pc=0, empty stack) ----------------
    addv(16'h1069, 1'b0, mkc(8'h69, 2'd0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0), 8'h01, 1'b0, 1'b0);
    addv(16'h0000, 1'b0, z,                                                              8'h01, 1'b0, 1'b0);
    addv(16'h2133, 1'b0, mkc(8'h00, 2'd2, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 8'h33, 1'b1), 8'h01, 1'b0, 1'b0);
    addv(16'h3044, 1'b0, mkc(8'h00, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h44, 1'b0), 8'h01, 1'b0, 1'b0);
    addv(16'h3145, 1'b1, mkc(8'h00, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h45, 1'b1), 8'h01, 1'b0, 1'b0);
    addv(16'h4700, 1'b0, mkc(8'h00, 2'd1, 4'hF, 1'b1, 1'b0, 1'b0, 4'h7, 8'h00, 1'b0), 8'h01, 1'b0, 1'b0);
    addv(16'h5A00, 1'b0, mkc(8'h00, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 4'hA, 8'h00, 1'b0), 8'h01, 1'b0, 1'b0);
    addv(16'h632B, 1'b0, mkc(8'h00, 2'd1, 4'h3, 1'b1, 1'b0, 1'b0, 4'hB, 8'h00, 1'b0), 8'h01, 1'b0, 1'b0);
    addv(16'h7255, 1'b0, mkc(8'h00, 2'd2, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0, 8'h55, 1'b0), 8'h01, 1'b0, 1'b0);
    addv(16'h8412, 1'b0, mkc(8'h12, 2'd0, 4'h4, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0), 8'h01, 1'b0, 1'b0);
    addv(16'h9040, 1'b0, z, 8'h40, 1'b0, 1'b0);
    addv(16'hA010, 1'b1, z, 8'h10, 1'b0, 1'b0);
    addv(16'hA010, 1'b0, z, 8'h01, 1'b0, 1'b0);
    addv(16'hB010, 1'b0, z, 8'h10, 1'b0, 1'b0);
    addv(16'hB010, 1'b1, z, 8'h01, 1'b0, 1'b0);
    addv(16'hC020, 1'b0, z, 8'h20, 1'b0, 1'b0);
    addv(16'hD000, 1'b0, z, 8'h00, 1'b0, 1'b1);
    addv(16'hE000, 1'b0, z, 8'h00, 1'b1, 1'b0);
    addv(16'hF123, 1'b0, z, 8'h00, 1'b0, 1'b1);

    foreach (vt[i]) begin
      pc_rst    = 1'b1;
      use_mem   = 1'b0;
      instr_drv = vt[i].instr;
      flag      = vt[i].flag;
      #1;
      if (i == 0) begin
        chk_no_en("in_reset");
        chk("rst.pc", 32'(bus.pc), 32'h0);
        chk("rst.halted", 32'(bus.halted), 32'h0);
        chk("rst.fault", 32'(bus.fault), 32'h0);
      end
      @(negedge clk);
      pc_rst = 1'b0;
      #1;
      chk_ctl($sformatf("vec%0d", i), vt[i].c);
      step();
      chk($sformatf("vec%0d.pc_next", i), 32'(bus.pc),     32'(vt[i].npc));
      chk($sformatf("vec%0d.halted", i),  32'(bus.halted), 32'(vt[i].hlt));
      chk($sformatf("vec%0d.fault", i),   32'(bus.fault),  32'(vt[i].flt));
    end

    // ---------------- LDI 0 ; JZ 0x10, taken and not taken ----------------
    use_mem = 1'b1;
    for (int f = 1; f >= 0; f--) begin
      clear_prog();
      imem[8'h00] = 16'h1000;
      imem[8'h01] = 16'hA010;
      flag = f[0];
      do_reset();
      step();
      chk("jz.pc1", 32'(bus.pc), 32'h01);
      step();
      chk("jz.target", 32'(bus.pc), (f == 1) ? 32'h10 : 32'h02);
    end
    flag = 1'b0;

    // ---------------- four nested CALLs, four RETs, RET on empty ----------------
    clear_prog();
    imem[8'h00] = 16'hC010; imem[8'h10] = 16'hC020;
    imem[8'h20] = 16'hC030; imem[8'h30] = 16'hC040;
    imem[8'h40] = 16'hD000; imem[8'h31] = 16'hD000;
    imem[8'h21] = 16'hD000; imem[8'h11] = 16'hD000;
    imem[8'h01] = 16'hD000;
    do_reset();
    step(); chk("call1.pc", 32'(bus.pc), 32'h10);
    step(); chk("call2.pc", 32'(bus.pc), 32'h20);
    step(); chk("call3.pc", 32'(bus.pc), 32'h30);
    step(); chk("call4.pc", 32'(bus.pc), 32'h40);
    step(); chk("ret1.pc",  32'(bus.pc), 32'h31);
    step(); chk("ret2.pc",  32'(bus.pc), 32'h21);
    step(); chk("ret3.pc",  32'(bus.pc), 32'h11);
    step(); chk("ret4.pc",  32'(bus.pc), 32'h01);
    chk("ret4.fault", 32'(bus.fault), 32'h0);
    step();
    chk("ret_empty.fault", 32'(bus.fault), 32'h1);
    chk("ret_empty.pc",    32'(bus.pc),    32'h01);
    @(negedge clk);
    #2 pc_rst = 1'b1;
    #1;
    chk("midrst.pc",    32'(bus.pc),    32'h0);
    chk("midrst.fault", 32'(bus.fault), 32'h0);
    @(negedge clk);
    pc_rst = 1'b0;

    // ---------------- fifth CALL overflows; reset empties the stack ----------------
    imem[8'h40] = 16'hC050;
    do_reset();
    repeat (4) step();
    chk("call4b.pc", 32'(bus.pc), 32'h40);
    step();
    chk("call5.fault", 32'(bus.fault), 32'h1);
    chk("call5.pc",    32'(bus.pc),    32'h40);
    chk_no_en("call5");
    step();
    chk("call5.pc_frozen", 32'(bus.pc), 32'h40);
    @(negedge clk);
    #2 pc_rst = 1'b1;
    #1;
    chk("midrst2.pc",    32'(bus.pc),    32'h0);
    chk("midrst2.fault", 32'(bus.fault), 32'h0);
    @(negedge clk);
    pc_rst    = 1'b0;
    use_mem   = 1'b0;
    instr_drv = 16'hD000;
    step();
    chk("post_rst_ret.fault", 32'(bus.fault), 32'h1);
    use_mem = 1'b1;

    // ---------------- HLT at 0x05 ----------------
    clear_prog();
    imem[8'h05] = 16'hE000;
    imem[8'h06] = 16'h1011;
    do_reset();
    repeat (5) step();
    chk("hlt.pc_at", 32'(bus.pc), 32'h05);
    chk("hlt.not_yet", 32'(bus.halted), 32'h0);
    step();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("hlt%0d.halted", k), 32'(bus.halted), 32'h1);
      chk($sformatf("hlt%0d.pc", k),     32'(bus.pc),     32'h05);
      chk_no_en($sformatf("hlt%0d", k));
    end

    // ---------------- PC wrap and CALL at 0xFF ----------------
    clear_prog();
    imem[8'h00] = 16'h90FE;
    do_reset();
    step(); chk("wrap.fe", 32'(bus.pc), 32'hFE);
    step(); chk("wrap.ff", 32'(bus.pc), 32'hFF);
    step(); chk("wrap.00", 32'(bus.pc), 32'h00);
    clear_prog();
    imem[8'h00] = 16'h90FF;
    imem[8'hFF] = 16'hC080;
    imem[8'h80] = 16'hD000;
    do_reset();
    step(); chk("callff.pc", 32'(bus.pc), 32'hFF);
    step(); chk("callff.tgt", 32'(bus.pc), 32'h80);
    step(); chk("callff.ret", 32'(bus.pc), 32'h00);
    chk("callff.fault", 32'(bus.fault), 32'h0);

    // ---------------- random programs against the reference model ----------------
    for (int p = 0; p < 6; p++) begin
      logic [7:0] m_pc;
      logic [7:0] nxt;
      logic [7:0] stk [$];
      int         m_state;
      int         stuck;
      logic [15:0] ins;
      for (int i = 0; i < 256; i++) imem[i] = rnd_instr();
      do_reset();
      m_pc = 8'h00; m_state = 0; stuck = 0; stk.delete();
      for (int c = 0; c < 300; c++) begin
        if (c != 0) @(negedge clk);
        if (stuck > 8) begin
          pc_rst = 1'b1;
          #2 pc_rst = 1'b0;
          m_pc = 8'h00; m_state = 0; stuck = 0; stk.delete();
        end
        flag = 1'($urandom_range(0, 1));
        #1;
        ins = imem[m_pc];
        chk("rnd.pc",     32'(bus.pc),     32'(m_pc));
        chk("rnd.halted", 32'(bus.halted), (m_state == 1) ? 32'h1 : 32'h0);
        chk("rnd.fault",  32'(bus.fault),  (m_state == 2) ? 32'h1 : 32'h0);
        chk_ctl("rnd", ref_decode(ins, m_state == 0));
        if (m_state != 0) begin
          stuck++;
        end else begin
          nxt = m_pc + 8'h01;
          case (ins[15:12])
            4'h9: m_pc = ins[7:0];
            4'hA: m_pc = flag ? ins[7:0] : nxt;
            4'hB: m_pc = flag ? nxt : ins[7:0];
            4'hC: if (stk.size() == 4) m_state = 2;
                  else begin stk.push_back(nxt); m_pc = ins[7:0]; end
            4'hD: if (stk.size() == 0) m_state = 2;
                  else m_pc = stk.pop_back();
            4'hE: m_state = 1;
            4'hF: m_state = 2;
            default: m_pc = nxt;
          endcase
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Control and fetch stage of the one-cycle CPU, sitting directly upstream of `cpu_data`. Holds the program counter, addresses instruction memory, and decodes each 16-bit instruction combinationally into the `cpu_data` control bundle. Resolves jumps on the zero flag and handles CALL/RET through a small hardware return stack. A run/halt/fault state machine stops the core on HLT, an illegal opcode, or a stack error.

## Interface
- `WIDTH`, 8: data, address, and PC width.
- `IWIDTH`, 4: width of the ALU operation code.
- `INSTR_WIDTH`, 16: instruction word width.
- `REG_F_SEL_SIZE`, 4: width of the register-file select.
- `IN_B_SEL_SIZE`, 2: width of the ALU B-input mux select.
- `STACK_DEPTH`, 4: number of return-stack entries (power of two).

Ports:
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `pc_rst`  in  1  asynchronous active-high reset.
- `instr`  in  INSTR_WIDTH  instruction at `pc`, from an asynchronous-read instruction memory.
- `flag_z_in`  in  1  zero flag from `cpu_data`.
- `pc`  out  WIDTH  instruction-memory address.
- `reg_f_sel`  out  REG_F_SEL_SIZE  register-file select.
- `en_reg_f`  out  1  register-file write enable.
- `d_mem_addr`  out  WIDTH  data-memory address operand.
- `d_mem_addr_mode`  out  1  data-memory address mode: 0 = from operand, 1 = from register file.
- `en_d_mem`  out  1  data-memory write enable.
- `in_b_sel`  out  IN_B_SEL_SIZE  ALU B source: 00 = imm, 01 = register file, 10 = data memory.
- `imm`  out  WIDTH  immediate value.
- `alu_out`  out  IWIDTH  ALU operation code.
- `en_acc`  out  1  accumulator load enable.
- `halted`  out  1  core is in HALT.
- `fault`  out  1  core is in FAULT.

## Operation
- Instruction fields:
  - `op` = instr[15:12]
  - `sub` = instr[11:8]
  - `opd` = instr[7:0]
- Opcode meanings:
  - 0 NOP: no enables.
  - 1 LDI: imm=opd, in_b_sel=00, alu_out=F (pass B), en_acc.
  - 2 LD: d_mem_addr=opd, d_mem_addr_mode=sub[0], in_b_sel=10, alu_out=F, en_acc.
  - 3 ST: d_mem_addr=opd, d_mem_addr_mode=sub[0], en_d_mem.
  - 4 LDR: reg_f_sel=sub, in_b_sel=01, alu_out=F, en_acc.
  - 5 STR: reg_f_sel=sub, en_reg_f.
  - 6 ALUR: alu_out=sub, reg_f_sel=opd[3:0], in_b_sel=01, en_acc.
  - 7 ALUM: alu_out=sub, d_mem_addr=opd, in_b_sel=10, en_acc.
  - 8 ALUI: alu_out=sub, imm=opd, in_b_sel=00, en_acc.
  - 9 JMP opd.
  - A JZ: jump to opd if flag_z_in=1.
  - B JNZ: jump to opd if flag_z_in=0.
  - C CALL: push pc+1, then jump to opd.
  - D RET: pop into pc.
  - E HLT.
  - F illegal.
- Fields not used by an opcode are driven to 0. `alu_out` defaults to 0.
- State machine:
  - RUN: decode `instr` and advance `pc`.
  - HALT: entered on HLT.
  - FAULT: entered on opcode F, CALL with the stack full, or RET with the stack empty.
  - HALT and FAULT exit only through `pc_rst`.
- In HALT and FAULT:
  - all enables (en_acc, en_reg_f, en_d_mem) are 0.
  - `pc` is frozen.
  - the stack is frozen.
- The faulting instruction produces no side effects: no enable, no push, no pop, and the PC is unchanged.
- PC arithmetic is modulo 2^WIDTH: 0xFF+1 → 0x00, and CALL at 0xFF pushes 0x00.
- Return stack: LIFO of WIDTH-bit entries with a pointer of $clog2(STACK_DEPTH)+1 bits.
  - Full when the pointer equals STACK_DEPTH.
  - Empty when the pointer is 0.

## Timing
- Reset values:
  - pc=0x00, stack pointer=0, state=RUN.
  - `halted`=0, `fault`=0.
  - While `pc_rst`=1, all enables are forced to 0.
- Decode is zero-latency: control outputs are combinational from `instr`, `flag_z_in`, and state within the same cycle.
- Registered updates at the rising edge:
  - pc ← next PC.
  - push or pop.
  - state.
- Branch resolution is in-cycle and has no delay slot; the target instruction executes in the next cycle.
- `halted` and `fault` assert in the cycle after the triggering instruction.
- Reset asserted mid-program clears pc, the stack pointer, and the state immediately, without waiting for a clock edge.
- `flag_z_in` is sampled in the same cycle as JZ/JNZ. It reflects the accumulator written by the preceding instruction.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_NOP … OP_ILL);
  - IN_B_SEL codes (B_IMM, B_REG, B_MEM);
  - ALU_PASS_B = 4'hF;
  - state enum (ST_RUN, ST_HALT, ST_FAULT).
- `cpu_data` uses the same package.
- One sub-module, `cpu_call_stack`, implements the return stack.
  - Inputs: clk, pc_rst, push, pop, din.
  - Outputs: dout, full, empty.
  - Push and pop requests are pre-qualified by `cpu_ctrl`.

## Test plan
- Reset, then `instr`=0x1069 (LDI 0x69): imm=0x69, in_b_sel=00, alu_out=F, en_acc=1; pc 0→1.
- Program LDI 0 ; JZ 0x10 with flag_z_in=1: pc=0x10 next cycle. Repeat with flag_z_in=0: pc=0x02.
- Four nested CALLs then four RETs: pc returns to each call site+1 in LIFO order. A fifth CALL → fault=1, pc frozen, no enables.
- RET with an empty stack → fault=1. A following `pc_rst` pulse mid-cycle → pc=0, fault=0, stack empty immediately.
- HLT at 0x05: halted=1 from the next cycle; pc stays 0x05 and all enables are 0 for 20 cycles.
- Sequential code at 0xFF: pc wraps to 0x00. CALL at 0xFF then RET: returns to 0x00. Opcode F → fault with no write enables.
